// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main control: Moore FSM decoding datapath controls from the registered state.
// Latency: outputs follow the state register; illegal_op is a registered pulse one cycle after DECODE.
// Backpressure: none; the FSM advances every clock and opcode is only sampled in DECODE and MEMADR.
module multicycle_control #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    output logic                   pc_write,
    output logic                   pc_write_cond,
    output logic                   i_or_d,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   mem_to_reg,
    output logic                   ir_write,
    output logic                   alu_src_a,
    output logic                   reg_write,
    output logic                   reg_dst,
    output logic [1:0]             pc_source,
    output logic [1:0]             alu_op,
    output logic [1:0]             alu_src_b,
    output logic [3:0]             state,
    output logic                   illegal_op,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t                 state_q, state_d;
    logic                   illegal_q, illegal_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   retire;

    // State, illegal pulse and retire counter registers; reset abandons any instruction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    // Next-state selection; only DECODE and MEMADR look at the opcode.
    always_comb begin
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECUTE: state_d = S_RTYPE_WB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            default:   state_d = S_FETCH;
        endcase
    end

    // An instruction retires on the edge leaving its terminal state; the counter wraps freely.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_MEMWB, S_MEMWRITE, S_RTYPE_WB,
            S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
            default:                     retire = 1'b0;
        endcase
        count_d = retire ? count_q + COUNT_WIDTH'(1) : count_q;
    end

    // Moore output decode; reset gates everything so no write strobe escapes while held.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        alu_src_a     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        pc_source     = 2'b00;
        alu_op        = 2'b00;
        alu_src_b     = 2'b00;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    alu_src_b = 2'b01;
                    pc_write  = 1'b1;
                end
                S_DECODE:  alu_src_b = 2'b11;
                S_MEMADR, S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMREAD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_RTYPE_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                S_ADDI_WB: reg_write = 1'b1;
                default: ;
            endcase
        end
    end

    assign state         = state_q;
    assign illegal_op    = illegal_q;
    assign retired_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction table, reset corner cases and random instruction mix.
// Latency: one check per cycle, sampled 1ns after each rising edge.
// Backpressure: none; a 4-bit-counter instance runs in lockstep to exercise counter wrap.
module tb_multicycle_control;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'd0;

    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg;
    logic        ir_write, alu_src_a, reg_write, reg_dst;
    logic [1:0]  pc_source, alu_op, alu_src_b;
    logic [3:0]  state;
    logic        illegal_op;
    logic [15:0] retired_count;

    logic        pc_write4, pc_write_cond4, i_or_d4, mem_read4, mem_write4, mem_to_reg4;
    logic        ir_write4, alu_src_a4, reg_write4, reg_dst4;
    logic [1:0]  pc_source4, alu_op4, alu_src_b4;
    logic [3:0]  state4;
    logic        illegal_op4;
    logic [3:0]  retired_count4;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    bit prev_ill = 1'b0;
    int path_q[$];

    multicycle_control #(.COUNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .opcode(opcode),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .ir_write(ir_write), .alu_src_a(alu_src_a), .reg_write(reg_write),
        .reg_dst(reg_dst), .pc_source(pc_source), .alu_op(alu_op),
        .alu_src_b(alu_src_b), .state(state), .illegal_op(illegal_op),
        .retired_count(retired_count)
    );

    multicycle_control #(.COUNT_WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .opcode(opcode),
        .pc_write(pc_write4), .pc_write_cond(pc_write_cond4), .i_or_d(i_or_d4),
        .mem_read(mem_read4), .mem_write(mem_write4), .mem_to_reg(mem_to_reg4),
        .ir_write(ir_write4), .alu_src_a(alu_src_a4), .reg_write(reg_write4),
        .reg_dst(reg_dst4), .pc_source(pc_source4), .alu_op(alu_op4),
        .alu_src_b(alu_src_b4), .state(state4), .illegal_op(illegal_op4),
        .retired_count(retired_count4)
    );

    always #5 clock = ~clock;

    logic [15:0] ctrl, ctrl4;
    assign ctrl  = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
                    ir_write, alu_src_a, reg_write, reg_dst, pc_source, alu_op, alu_src_b};
    assign ctrl4 = {pc_write4, pc_write_cond4, i_or_d4, mem_read4, mem_write4, mem_to_reg4,
                    ir_write4, alu_src_a4, reg_write4, reg_dst4, pc_source4, alu_op4, alu_src_b4};

    function automatic logic [15:0] mk(input bit pw, input bit pwc, input bit iod, input bit mr,
                                       input bit mw, input bit mtr, input bit irw, input bit asa,
                                       input bit rw, input bit rd, input logic [1:0] ps,
                                       input logic [1:0] ao, input logic [1:0] asb);
        return {pw, pwc, iod, mr, mw, mtr, irw, asa, rw, rd, ps, ao, asb};
    endfunction

    // Expected control word for each state, straight from the state output tables.
    function automatic logic [15:0] exp_ctrl(input int s);
        case (s)
            0:  return mk(1,0,0,1,0,0,1,0,0,0, 2'b00, 2'b00, 2'b01);
            1:  return mk(0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b11);
            2:  return mk(0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 2'b10);
            3:  return mk(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
            4:  return mk(0,0,0,0,0,1,0,0,1,0, 2'b00, 2'b00, 2'b00);
            5:  return mk(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
            6:  return mk(0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b10, 2'b00);
            7:  return mk(0,0,0,0,0,0,0,0,1,1, 2'b00, 2'b00, 2'b00);
            8:  return mk(0,1,0,0,0,0,0,1,0,0, 2'b01, 2'b01, 2'b00);
            9:  return mk(1,0,0,0,0,0,0,0,0,0, 2'b10, 2'b00, 2'b00);
            10: return mk(0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 2'b10);
            11: return mk(0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00);
            default: return 16'h0000;
        endcase
    endfunction

    // Instruction-level reference: the list of states an opcode walks through.
    task automatic build_path(input logic [5:0] op);
        path_q.delete();
        path_q.push_back(0);
        path_q.push_back(1);
        case (op)
            OP_LW:   begin path_q.push_back(2); path_q.push_back(3); path_q.push_back(4); end
            OP_SW:   begin path_q.push_back(2); path_q.push_back(5); end
            OP_R:    begin path_q.push_back(6); path_q.push_back(7); end
            OP_BEQ:  path_q.push_back(8);
            OP_J:    path_q.push_back(9);
            OP_ADDI: begin path_q.push_back(10); path_q.push_back(11); end
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_ctrl"}, 32'(ctrl), 32'd0);
        chk({tag, "_ctrl4"}, 32'(ctrl4), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal_op), 32'd0);
        chk({tag, "_count"}, 32'(retired_count), 32'd0);
        chk({tag, "_count4"}, 32'(retired_count4), 32'd0);
    endtask

    // Walk one instruction along path_q, starting 1ns after entering FETCH.
    // Opcode is scrambled outside DECODE/MEMADR to show it is ignored there.
    task automatic run_instr(input logic [5:0] op, input string tag);
        bit legal;
        int st;
        legal = (path_q.size() > 2);
        for (int i = 0; i < path_q.size(); i++) begin
            st = path_q[i];
            opcode = (st == 1 || st == 2) ? op : 6'($urandom);
            chk({tag, "_state"}, 32'(state), 32'(st));
            chk({tag, "_ctrl"}, 32'(ctrl), 32'(exp_ctrl(st)));
            chk({tag, "_ctrl4"}, 32'(ctrl4), 32'(exp_ctrl(st)));
            chk({tag, "_illegal"}, 32'(illegal_op), (i == 0 && prev_ill) ? 32'd1 : 32'd0);
            chk({tag, "_count"}, 32'(retired_count), 32'(model_cnt % 65536));
            chk({tag, "_count4"}, 32'(retired_count4), 32'(model_cnt % 16));
            @(posedge clock);
            #1;
        end
        if (legal) model_cnt++;
        prev_ill = !legal;
    endtask

    typedef struct {
        logic [5:0] op;
        int         len;
        int         seq [6];
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{op: OP_LW,   len: 5, seq: '{0, 1, 2, 3, 4, 0}};
        vecs[1] = '{op: OP_R,    len: 4, seq: '{0, 1, 6, 7, 0, 0}};
        vecs[2] = '{op: OP_BEQ,  len: 3, seq: '{0, 1, 8, 0, 0, 0}};
        vecs[3] = '{op: OP_J,    len: 3, seq: '{0, 1, 9, 0, 0, 0}};
        vecs[4] = '{op: OP_BAD,  len: 2, seq: '{0, 1, 0, 0, 0, 0}};
        vecs[5] = '{op: OP_SW,   len: 4, seq: '{0, 1, 2, 5, 0, 0}};
        vecs[6] = '{op: OP_ADDI, len: 4, seq: '{0, 1, 10, 11, 0, 0}};

        // Held in reset across an edge: everything quiet, including FETCH strobes.
        reset = 1'b1;
        #12;
        check_all_zero("reset_hold");
        @(negedge clock);
        reset = 1'b0;
        #1;

        // Directed instruction table; FETCH outputs must already be visible here.
        for (int v = 0; v < 7; v++) begin
            path_q.delete();
            for (int k = 0; k < vecs[v].len; k++) path_q.push_back(vecs[v].seq[k]);
            run_instr(vecs[v].op, $sformatf("vec%0d", v));
        end
        chk("after_table_count", 32'(retired_count), 32'd6);

        // Asynchronous reset while in MEMREAD, checked before the next edge.
        opcode = 6'($urandom);
        @(posedge clock); #1;
        opcode = OP_LW;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("mid_memread_state", 32'(state), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clock);
        reset = 1'b0;
        #1;
        model_cnt = 0;
        prev_ill  = 1'b0;

        // Random instruction mix against the instruction-level model.
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            case ($urandom_range(0, 7))
                0: op = OP_LW;
                1: op = OP_SW;
                2: op = OP_R;
                3: op = OP_BEQ;
                4: op = OP_J;
                5: op = OP_ADDI;
                default: op = 6'($urandom);
            endcase
            build_path(op);
            run_instr(op, $sformatf("rnd%0d", n));
        end

        // Sixteen stores from a fresh reset: the 4-bit counter wraps 15 -> 0.
        @(negedge clock);
        reset = 1'b1;
        #2;
        check_all_zero("wrap_reset");
        @(negedge clock);
        reset = 1'b0;
        #1;
        model_cnt = 0;
        prev_ill  = 1'b0;
        for (int n = 0; n < 16; n++) begin
            build_path(OP_SW);
            if (n == 15) chk("wrap_count4_15", 32'(retired_count4), 32'd15);
            run_instr(OP_SW, $sformatf("sw%0d", n));
        end
        chk("wrap_count4_0", 32'(retired_count4), 32'd0);
        chk("wrap_count16", 32'(retired_count), 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one parameter: COUNT_WIDTH, default 16, width of retired_count.
REQ-002 The block SHALL have a port clock, input, width 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have a port reset, input, width 1, asynchronous active-high reset.
REQ-004 The block SHALL have a port opcode, input, width 6, instruction bits [31:26] from the IR, valid from DECODE onward.
REQ-005 The block SHALL have these 1-bit outputs: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst.
REQ-006 The block SHALL have these 2-bit outputs: pc_source, alu_op and alu_src_b. alu_op carries 00=add, 01=subtract, 10=use funct, which is the encoding the ALU control stage consumes.
REQ-007 The block SHALL have the following outputs: state (4 bits, current state code), illegal_op (1 bit, one-cycle pulse) and retired_count (COUNT_WIDTH bits, count of completed instructions).

Function
REQ-008 The block SHALL be a Moore FSM; all control outputs SHALL be decoded from the registered state only. No output path SHALL exist from opcode to a control output.
REQ-009 The state codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, RTYPE_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11. Codes 12-15 SHALL return to FETCH on the next edge.
REQ-010 Any output not listed for a state SHALL be 0 in that state.
REQ-011 FETCH SHALL drive: mem_read=1, ir_write=1, alu_src_b=01, alu_op=00, pc_write=1, pc_source=00. The next state SHALL be DECODE.
REQ-012 DECODE SHALL drive: alu_src_b=11, alu_op=00.
REQ-013 The next state from DECODE SHALL be chosen from opcode as follows:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 (R-type) -> EXECUTE
- 000100 (beq) -> BRANCH
- 000010 (j) -> JUMP
- 001000 (addi) -> ADDI_EX
- any other value -> FETCH
REQ-014 On an unsupported opcode in DECODE, illegal_op SHALL be 1 during the cycle following the DECODE->FETCH edge (registered pulse), and retired_count SHALL NOT change.
REQ-015 MEMADR SHALL drive: alu_src_a=1, alu_src_b=10, alu_op=00. The next state SHALL be MEMREAD if opcode=100011, otherwise MEMWRITE.
REQ-016 MEMREAD SHALL drive: mem_read=1, i_or_d=1. The next state SHALL be MEMWB.
REQ-017 MEMWB SHALL drive: reg_write=1, mem_to_reg=1, reg_dst=0. The next state SHALL be FETCH.
REQ-018 MEMWRITE SHALL drive: mem_write=1, i_or_d=1. The next state SHALL be FETCH.
REQ-019 EXECUTE SHALL drive: alu_src_a=1, alu_src_b=00, alu_op=10. The next state SHALL be RTYPE_WB.
REQ-020 RTYPE_WB SHALL drive: reg_dst=1, reg_write=1, mem_to_reg=0. The next state SHALL be FETCH.
REQ-021 BRANCH SHALL drive: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. The next state SHALL be FETCH.
REQ-022 JUMP SHALL drive: pc_write=1, pc_source=10. The next state SHALL be FETCH.
REQ-023 ADDI_EX SHALL drive: alu_src_a=1, alu_src_b=10, alu_op=00. The next state SHALL be ADDI_WB.
REQ-024 ADDI_WB SHALL drive: reg_write=1, reg_dst=0, mem_to_reg=0. The next state SHALL be FETCH.
REQ-025 Instruction latencies, counted FETCH through the terminal state inclusive, SHALL be: lw=5, sw=4, R-type=4, addi=4, beq=3, j=3 cycles.
REQ-026 retired_count SHALL increment by 1 on each edge that leaves a terminal state (MEMWB, MEMWRITE, RTYPE_WB, BRANCH, JUMP, ADDI_WB).
REQ-027 retired_count SHALL wrap from all-ones to 0 without saturating or flagging.
REQ-028 A change in opcode while the FSM is outside DECODE and MEMADR SHALL have no effect.

Reset
REQ-029 While reset=1, the block SHALL force state=FETCH, retired_count=0 and illegal_op=0.
REQ-030 While reset=1, the block SHALL force every control output to 0, including the FETCH outputs, so no memory, PC or register write occurs during reset.
REQ-031 When reset is asserted mid-instruction, the block SHALL abandon that instruction immediately (asynchronously) without incrementing retired_count.
REQ-032 The first edge after reset deasserts SHALL execute FETCH, with FETCH outputs visible as soon as reset=0.

Verification
REQ-033 The bench SHALL cover reset, then opcode=100011 -> state sequence 0,1,2,3,4,0; retired_count=1 after 5 cycles; mem_to_reg=1 only in state 4.
REQ-034 The bench SHALL cover opcode=000000 -> sequence 0,1,6,7,0; alu_op=10 in state 6; reg_dst=1 and reg_write=1 in state 7.
REQ-035 The bench SHALL cover opcode=000100, then 000010 -> sequences 0,1,8,0 and 0,1,9,0; pc_source=01 with pc_write_cond=1 in state 8, then pc_source=10 with pc_write=1 in state 9; retired_count=2.
REQ-036 The bench SHALL cover opcode=111111 -> sequence 0,1,0; illegal_op=1 for exactly one cycle; retired_count unchanged.
REQ-037 The bench SHALL cover reset asserted asynchronously in MEMREAD (state 3) -> state=0 and all outputs 0 before the next clock edge; retired_count=0.
REQ-038 The bench SHALL cover COUNT_WIDTH=4 with 16 consecutive sw instructions -> retired_count wraps 15->0 on the 16th completion.
